// File: rtl/prenc_rr_arb_if.sv
// prenc_rr_arb_if: request/grant bundle between requesters and the arbiter.
// With PRENC_TIMEOUT_EN defined the bundle also carries the timeout error pulse.
interface prenc_rr_arb_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         en;
    logic         mode;
    logic [N-1:0] D;
    logic         ack;
    logic [N-1:0] grant;
    logic [W-1:0] idx;
    logic         Y;
`ifdef PRENC_TIMEOUT_EN
    logic         err;
    modport master (output en, mode, D, ack, input grant, idx, Y, err);
    modport slave  (input en, mode, D, ack, output grant, idx, Y, err);
`else
    modport master (output en, mode, D, ack, input grant, idx, Y);
    modport slave  (input en, mode, D, ack, output grant, idx, Y);
`endif
endinterface

// File: rtl/prenc_rr_arb.sv
// prenc_rr_arb: registered N-way fixed-priority / round-robin arbiter with held grants.
// Optional PRENC_TIMEOUT_EN adds a TMO-cycle hold limit and a one-cycle err pulse.
module prenc_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
`ifdef PRENC_TIMEOUT_EN
    ,
    parameter int TMO = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    prenc_rr_arb_if.slave bus
);
    if (W != $clog2(N) || N < 2 || N > 32) begin : g_bad_param
        $error("prenc_rr_arb: need 2 <= N <= 32 and W == clog2(N)");
    end
`ifdef PRENC_TIMEOUT_EN
    if (TMO < 1 || TMO > 256) begin : g_bad_tmo
        $error("prenc_rr_arb: TMO must be in 1..256");
    end
`endif

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       r_state, w_nxt_state;
    logic [N-1:0] r_grant, w_nxt_grant;
    logic [W-1:0] r_idx, w_nxt_idx;
    logic [W-1:0] r_last, w_nxt_last;
    logic         r_y, w_nxt_y;
    logic [N-1:0] w_req;
    logic [W-1:0] w_win;
    logic         w_tmo;
    logic         w_release;
    logic         w_arb;

    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] req);
        fixed_pick = '0;
        for (int i = 0; i < N; i++)
            if (req[i]) fixed_pick = W'(i);
    endfunction

    // Scans from the end of the search order so the earliest hit (last-1) is written last.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] last);
        int j;
        rr_pick = '0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + N - k) % N;
            if (req[j]) rr_pick = W'(j);
        end
    endfunction

`ifdef PRENC_TIMEOUT_EN
    logic [7:0] r_cnt, w_nxt_cnt;
    logic       r_err;
    assign w_tmo     = (r_state == GRANT) && (r_cnt == 8'(TMO - 1));
    assign w_nxt_cnt = w_arb ? 8'd0 : (r_state == GRANT) ? r_cnt + 8'd1 : r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_nxt_cnt;
            r_err <= w_tmo;
        end
    end
    assign bus.err = r_err;
`else
    assign w_tmo = 1'b0;
`endif

    // On release the current holder is excluded so another requester is served first.
    assign w_req     = bus.D & ((r_state == GRANT) ? ~(N'(1) << r_idx) : {N{1'b1}});
    assign w_release = (r_state == GRANT) && (bus.ack || !bus.D[r_idx] || w_tmo);
    assign w_arb     = bus.en && (|w_req) && ((r_state == IDLE) || w_release);
    assign w_win     = bus.mode ? rr_pick(w_req, r_last) : fixed_pick(w_req);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        w_nxt_idx   = r_idx;
        w_nxt_last  = r_last;
        w_nxt_y     = r_y;
        if (w_arb) begin
            w_nxt_state = GRANT;
            w_nxt_grant = N'(1) << w_win;
            w_nxt_idx   = w_win;
            w_nxt_last  = w_win;
            w_nxt_y     = 1'b1;
        end else if (w_release) begin
            w_nxt_state = IDLE;
            w_nxt_grant = '0;
            w_nxt_idx   = '0;
            w_nxt_y     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
            r_idx   <= w_nxt_idx;
            r_last  <= w_nxt_last;
            r_y     <= w_nxt_y;
        end
    end

    assign bus.grant = r_grant;
    assign bus.idx   = r_idx;
    assign bus.Y     = r_y;
endmodule

// File: tb/tb_prenc_rr_arb.sv
// tb_prenc_rr_arb: directed-vector bench for prenc_rr_arb with N=4.
// Timeout vectors run only when PRENC_TIMEOUT_EN is defined (DUT built with TMO=4).
module tb_prenc_rr_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    prenc_rr_arb_if #(.N(4), .W(2)) bus ();

`ifdef PRENC_TIMEOUT_EN
    prenc_rr_arb #(.N(4), .W(2), .TMO(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    prenc_rr_arb #(.N(4), .W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] i, input logic y);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".idx"}, 32'(bus.idx), 32'(i));
        chk({tag, ".Y"}, 32'(bus.Y), 32'(y));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.mode = 1'b0;
        bus.D = 4'b1111;
        bus.ack = 1'b0;
        repeat (3) step();
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("post_reset_fixed", 4'b1000, 2'd3, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0);
        bus.D = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        chk_out("idle_no_req", 4'b0000, 2'd0, 1'b0);

        bus.D = 4'b0101;
        step();
        chk_out("fixed_first", 4'b0100, 2'd2, 1'b1);
        bus.ack = 1'b1;
        step();
        chk_out("fixed_backtoback", 4'b0001, 2'd0, 1'b1);
        bus.D = 4'b0000;
        step();
        chk_out("fixed_ack_empty", 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("ack_in_idle", 4'b0000, 2'd0, 1'b0);

        bus.mode = 1'b1;
        bus.D = 4'b1111;
        step();
        chk_out("rr0", 4'b1000, 2'd3, 1'b1);
        step();
        chk_out("rr1", 4'b0100, 2'd2, 1'b1);
        step();
        chk_out("rr2", 4'b0010, 2'd1, 1'b1);
        step();
        chk_out("rr3", 4'b0001, 2'd0, 1'b1);
        step();
        chk_out("rr4", 4'b1000, 2'd3, 1'b1);
        bus.ack = 1'b0;
        bus.D = 4'b0000;
        step();
        chk_out("rr_drop", 4'b0000, 2'd0, 1'b0);

        bus.mode = 1'b0;
        bus.D = 4'b0010;
        step();
        chk_out("hold_grant", 4'b0010, 2'd1, 1'b1);
        bus.D = 4'b1010;
        bus.mode = 1'b1;
        step();
        chk_out("hold_other_req", 4'b0010, 2'd1, 1'b1);
        bus.mode = 1'b0;
        bus.D = 4'b1000;
        step();
        chk_out("drop_switch", 4'b1000, 2'd3, 1'b1);
        bus.D = 4'b0000;
        step();
        chk_out("drop_idle", 4'b0000, 2'd0, 1'b0);

        bus.en = 1'b0;
        bus.D = 4'b1000;
        step();
        chk_out("en_block0", 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("en_block1", 4'b0000, 2'd0, 1'b0);
        bus.en = 1'b1;
        step();
        chk_out("en_grant", 4'b1000, 2'd3, 1'b1);
        bus.en = 1'b0;
        bus.D = 4'b1001;
        step();
        chk_out("en_off_hold", 4'b1000, 2'd3, 1'b1);
        bus.ack = 1'b1;
        step();
        chk_out("en_off_release", 4'b0000, 2'd0, 1'b0);
        bus.ack = 1'b0;
        step();
        chk_out("en_off_idle", 4'b0000, 2'd0, 1'b0);

        bus.en = 1'b1;
        bus.D = 4'b0100;
        step();
        chk_out("ackwin_grant", 4'b0100, 2'd2, 1'b1);
        bus.ack = 1'b1;
        step();
        chk_out("ackwin_release", 4'b0000, 2'd0, 1'b0);
        bus.ack = 1'b0;
        step();
        chk_out("ackwin_regrant", 4'b0100, 2'd2, 1'b1);
        bus.D = 4'b0000;
        step();
        chk_out("ackwin_idle", 4'b0000, 2'd0, 1'b0);

`ifdef PRENC_TIMEOUT_EN
        bus.D = 4'b0010;
        step();
        chk_out("tmo_grant", 4'b0010, 2'd1, 1'b1);
        chk("tmo_err0", 32'(bus.err), 32'd0);
        repeat (3) step();
        chk_out("tmo_held", 4'b0010, 2'd1, 1'b1);
        chk("tmo_err_held", 32'(bus.err), 32'd0);
        step();
        chk_out("tmo_release", 4'b0000, 2'd0, 1'b0);
        chk("tmo_err_pulse", 32'(bus.err), 32'd1);
        step();
        chk_out("tmo_regrant", 4'b0010, 2'd1, 1'b1);
        chk("tmo_err_clear", 32'(bus.err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/prenc_rr_arb.md
Name: prenc_rr_arb

Overview:
- Parametrised, registered successor to the 4-to-2 priority encoder.
- Samples N request lines and produces a one-hot grant, a binary index and a valid flag.
- Selectable fixed-priority or round-robin mode.
- The grant is held until the requester acknowledges or drops its request; the next winner follows back-to-back.
- Sits between request sources and a shared resource.

Parameters:
- N, 4, number of request lines; legal range 2..32.
- W, 2, index width; must equal clog2(N); checked at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; 0 blocks new grants
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin
- D  input  N  request lines; D[i]=1 means requester i wants the resource
- ack  input  1  grantee finished; releases the grant
- grant  output  N  one-hot registered grant
- idx  output  W  binary index of the granted line; valid only when Y=1
- Y  output  1  valid: a grant is active

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, idx=0, Y=0, state=IDLE, last=0.
  - Takes effect immediately, including mid-grant.
- States are IDLE and GRANT.
- IDLE:
  - If en=1 and D!=0 at a rising edge, pick winner w.
  - At that same edge: grant=1<<w, idx=w, Y=1, last=w, go to GRANT.
  - Latency: request to Y is 1 cycle.
  - If en=0 or D=0, all outputs stay 0.
- Fixed mode (mode=0): w is the highest i with D[i]=1.
- Round-robin mode (mode=1):
  - Search order is last-1, last-2, ..., 0, N-1, ..., last; w is the first set bit in that order.
  - After reset (last=0) the order is N-1 down to 0, so the first pick matches fixed mode.
- GRANT:
  - Outputs hold while ack=0 and D[idx]=1, independent of changes on other D bits, mode or en.
- Release occurs at a rising edge when ack=1 or D[idx]=0.
  - If en=1 and D has any bit set other than idx, re-arbitrate at the same edge: new grant, Y stays 1, no bubble.
  - For this re-arbitration, D[idx] is ignored even if still set.
  - Otherwise grant=0, Y=0, go to IDLE.
- Simultaneous ack=1 and D[idx]=1: ack wins; the grant is released.
- ack while in IDLE: ignored.
- mode is sampled only at arbitration edges; changing it mid-grant has no effect until the next arbitration.
- last updates only on a new grant; fixed-mode grants also update last.
- Invariants: grant is always one-hot or zero; grant!=0 exactly when Y=1; idx matches grant when Y=1.

Optional Feature:
- Macro: PRENC_TIMEOUT_EN.
- When defined:
  - Adds parameter TMO (default 16), an 8-bit hold counter, and output port err (1 bit).
  - Counter resets on each new grant and increments every GRANT cycle.
  - On reaching TMO-1 without release, the grant is force-released at the next edge, exactly as if ack=1.
  - err pulses high for 1 cycle, registered, reset 0.
- When undefined: no counter, no err port; a grant can be held indefinitely.

Test Plan (N=4):
- Reset: rst_n=0 for 3 cycles with D=4'b1111 -> grant=0, idx=0, Y=0; reassert rst_n=0 mid-grant -> outputs clear immediately, without waiting for a clock edge.
- Fixed priority: mode=0, en=1, D=4'b0101 -> 1 cycle later grant=4'b0100, idx=2, Y=1; ack=1 for 1 cycle -> grant=4'b0001, idx=0, Y=1 with no bubble; ack with D=0 -> Y=0.
- Round-robin fairness: mode=1, D=4'b1111 held, ack pulsed each cycle -> idx sequence 3,2,1,0,3.
- Hold and drop: grant on idx=1; raise D[3] -> grant unchanged; drop D[1] -> next edge idx=3.
- Enable gating: en=0, D=4'b1000 -> Y stays 0; set en=1 -> Y=1, idx=3 after 1 cycle; en=0 during the grant -> grant held until ack.
- Timeout (PRENC_TIMEOUT_EN, TMO=4): D=4'b0010 held, ack=0 -> grant released after 4 cycles, err=1 for one cycle, then re-grant idx=1 from IDLE.
